// File: rtl/chacha_host_seq_if.sv
// Register bus between the ChaCha host sequencer and the core's register slave.
// One access per cycle; read_data returns combinationally during a read cycle.
interface chacha_host_seq_if;
  logic        cs;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output cs, we, addr, write_data, input read_data);
  modport slave  (input cs, we, addr, write_data, output read_data);
endinterface

// File: rtl/chacha_host_seq.sv
// Host-side sequencer: programs a ChaCha core over the register bus, polls for
// completion and captures the 512-bit result block.
module chacha_host_seq #(
  parameter int POLL_LIMIT    = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     mode_next,
  input  logic [255:0]             key,
  input  logic [95:0]              nonce,
  input  logic [4:0]               rounds,
  input  logic [511:0]             data_in,
  chacha_host_seq_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [511:0]             data_out
);

  localparam int CNT_W = $clog2(POLL_LIMIT + SETTLE_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, WR_ROUNDS, WR_KEYLEN, WR_KEY, WR_NONCE, WR_DATA, WR_CTRL,
    SETTLE, POLL, RD_OUT, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [511:0]       data_q, data_d;
  logic [255:0]       key_q, key_d;
  logic [95:0]        nonce_q, nonce_d;
  logic [4:0]         rounds_q, rounds_d;
  logic [511:0]       din_q, din_d;
  logic               mode_q, mode_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    data_d   = data_q;
    key_d    = key_q;
    nonce_d  = nonce_q;
    rounds_d = rounds_q;
    din_d    = din_q;
    mode_d   = mode_q;
    case (state_q)
      IDLE: if (start) begin
        key_d    = key;
        nonce_d  = nonce;
        rounds_d = rounds;
        din_d    = data_in;
        mode_d   = mode_next;
        err_d    = 1'b0;
        state_d  = mode_next ? WR_DATA : WR_ROUNDS;
      end
      WR_ROUNDS: state_d = WR_KEYLEN;
      WR_KEYLEN: state_d = WR_KEY;
      WR_KEY:    if (idx_q == 4'd7)  state_d = WR_NONCE; else idx_d = idx_q + 4'd1;
      WR_NONCE:  if (idx_q == 4'd2)  state_d = WR_DATA;  else idx_d = idx_q + 4'd1;
      WR_DATA:   if (idx_q == 4'd15) state_d = WR_CTRL;  else idx_d = idx_q + 4'd1;
      WR_CTRL:   state_d = (SETTLE_CYCLES == 0) ? POLL : SETTLE;
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = POLL;
        else cnt_d = cnt_q + 1'b1;
      end
      POLL: begin
        // Status bits [1:0] both set means the result block is ready.
        if (bus.read_data[1:0] == 2'b11) state_d = RD_OUT;
        else if (cnt_q == CNT_W'(POLL_LIMIT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else cnt_d = cnt_q + 1'b1;
      end
      RD_OUT: begin
        data_d[{~idx_q, 5'b0} +: 32] = bus.read_data;
        if (idx_q == 4'd15) state_d = DONE; else idx_d = idx_q + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Index and counter restart on every state entry so no group overruns.
    if (state_d != state_q) begin
      idx_d = '0;
      cnt_d = '0;
    end
  end

  // NOTE: reset here is synchronous (sampled on the clock edge), so it sits inside the edge branch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // NOTE: latched request fields need no reset; they are always loaded before first use.
  always_ff @(posedge clk) begin
    key_q    <= key_d;
    nonce_q  <= nonce_d;
    rounds_q <= rounds_d;
    din_q    <= din_d;
    mode_q   <= mode_d;
  end

  // Bus decode depends only on state and word index.
  always_comb begin
    bus.cs         = 1'b0;
    bus.we         = 1'b0;
    bus.addr       = 8'h00;
    bus.write_data = 32'h0;
    case (state_q)
      WR_ROUNDS: begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 8'h0b;
        bus.write_data = {27'h0, rounds_q};
      end
      WR_KEYLEN: begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 8'h0a;
        bus.write_data = 32'h1;
      end
      WR_KEY: begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = {4'h1, idx_q};
        bus.write_data = key_q[{~idx_q[2:0], 5'b0} +: 32];
      end
      WR_NONCE: begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = {4'h2, idx_q};
        case (idx_q[1:0])
          2'd0:    bus.write_data = nonce_q[95:64];
          2'd1:    bus.write_data = nonce_q[63:32];
          default: bus.write_data = nonce_q[31:0];
        endcase
      end
      WR_DATA: begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = {4'h4, idx_q};
        bus.write_data = din_q[{~idx_q, 5'b0} +: 32];
      end
      WR_CTRL: begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 8'h08;
        bus.write_data = mode_q ? 32'h2 : 32'h1;
      end
      POLL: begin
        bus.cs = 1'b1; bus.addr = 8'h09;
      end
      RD_OUT: begin
        bus.cs = 1'b1; bus.addr = {4'h8, idx_q};
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_chacha_host_seq.sv
// Scoreboard bench for chacha_host_seq: stimulus queues expected bus transfers
// and done records; a negedge monitor compares them against the DUT.
module tb_chacha_host_seq;
  localparam int POLL_LIMIT    = 1024;
  localparam int SETTLE_CYCLES = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         mode_next = 1'b0;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [4:0]   rounds = '0;
  logic [511:0] data_in = '0;
  logic         busy, done, err;
  logic [511:0] data_out;

  chacha_host_seq_if bus ();

  chacha_host_seq #(.POLL_LIMIT(POLL_LIMIT), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode_next(mode_next),
    .key(key), .nonce(nonce), .rounds(rounds), .data_in(data_in),
    .bus(bus), .busy(busy), .done(done), .err(err), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // ---------------- register slave model ----------------
  logic [31:0] regs [256];
  logic [31:0] sl_out [16];
  int          sl_polls = 0;
  int          ready_after = 10;
  logic [1:0]  pend = 2'b00;
  logic [31:0] rd;

  always @(posedge clk) begin
    if (bus.cs && bus.we) begin
      regs[bus.addr] <= bus.write_data;
      if (bus.addr == 8'h08) begin
        sl_polls <= 0;
        for (int i = 0; i < 16; i++) sl_out[i] <= regs[8'(64 + i)] ^ {16'hC0DE, 12'h000, 4'(i)};
      end
    end else if (bus.cs && bus.addr == 8'h09) begin
      sl_polls <= sl_polls + 1;
    end
  end

  always_comb begin
    rd = 32'h0;
    if (bus.cs && !bus.we) begin
      if (bus.addr == 8'h09)
        rd = (ready_after != 0 && sl_polls >= ready_after - 1) ? 32'h3 : {30'h0, pend};
      else if (bus.addr[7:4] == 4'h8)
        rd = sl_out[bus.addr[3:0]];
    end
  end
  assign bus.read_data = rd;

  // ---------------- scoreboard ----------------
  typedef struct packed { logic we; logic [7:0] addr; logic [31:0] wd; } bus_t;
  typedef struct { logic err; logic [511:0] dout; int lat; } done_t;

  bus_t  exp_bus [$];
  done_t exp_done [$];
  bus_t  e_bus;
  done_t e_done;
  logic [511:0] last_out = '0;

  task automatic push_bus(input logic we, input logic [7:0] a, input logic [31:0] d);
    bus_t b;
    b.we = we; b.addr = a; b.wd = d;
    exp_bus.push_back(b);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.cs === 1'b1) begin
        if (exp_bus.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bus act=we%0b addr=%h data=%h req=no transfer",
                   bus.we, bus.addr, bus.write_data);
        end else begin
          e_bus = exp_bus.pop_front();
          check("bus_xfer", {bus.we, bus.addr, bus.we ? bus.write_data : 32'h0},
                {e_bus.we, e_bus.addr, e_bus.we ? e_bus.wd : 32'h0});
        end
      end else begin
        check("bus_idle", {bus.we, bus.addr, bus.write_data}, '0);
      end
      if (done === 1'b1) begin
        if (exp_done.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done act=1 req=0");
        end else begin
          e_done = exp_done.pop_front();
          check("done_err", err, e_done.err);
          check("done_data", data_out, e_done.dout);
          check("done_latency", cyc - start_cyc + 1, e_done.lat);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] out_word(input logic [511:0] d, input int i);
    return d[(15 - i) * 32 +: 32] ^ {16'hC0DE, 12'h000, 4'(i)};
  endfunction

  task automatic push_writes(input bit m, input logic [255:0] k, input logic [95:0] nc,
                             input logic [4:0] r, input logic [511:0] din);
    if (!m) begin
      push_bus(1'b1, 8'h0b, {27'h0, r});
      push_bus(1'b1, 8'h0a, 32'h1);
      for (int i = 0; i < 8; i++) push_bus(1'b1, 8'(16 + i), k[(7 - i) * 32 +: 32]);
      for (int i = 0; i < 3; i++) push_bus(1'b1, 8'(32 + i), nc[(2 - i) * 32 +: 32]);
    end
    for (int i = 0; i < 16; i++) push_bus(1'b1, 8'(64 + i), din[(15 - i) * 32 +: 32]);
    push_bus(1'b1, 8'h08, m ? 32'h2 : 32'h1);
  endtask

  task automatic run_seq(input bit m, input logic [255:0] k, input logic [95:0] nc,
                         input logic [4:0] r, input logic [511:0] din,
                         input int ready, input logic [1:0] pnd, input bit hold);
    done_t dr;
    int    polls;
    int    waited;
    bit    timeout;
    logic [511:0] o;
    ready_after = ready;
    pend        = pnd;
    push_writes(m, k, nc, r, din);
    timeout = (ready == 0);
    polls   = timeout ? POLL_LIMIT : ready;
    for (int i = 0; i < polls; i++) push_bus(1'b0, 8'h09, 32'h0);
    o = last_out;
    if (!timeout)
      for (int i = 0; i < 16; i++) begin
        push_bus(1'b0, 8'(128 + i), 32'h0);
        o[(15 - i) * 32 +: 32] = out_word(din, i);
      end
    dr.err  = timeout;
    dr.dout = o;
    dr.lat  = (m ? 17 : 30) + SETTLE_CYCLES + polls + (timeout ? 0 : 16) + 1;
    exp_done.push_back(dr);
    last_out = o;

    @(negedge clk);
    mode_next = m; key = k; nonce = nc; rounds = r; data_in = din;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    if (hold) begin
      // Keep start asserted and scramble inputs: the running sequence must ignore both.
      key = ~k; data_in = ~din; rounds = ~r; mode_next = ~m;
    end else begin
      start = 1'b0;
    end
    waited = 0;
    while (done !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL done_timeout act=no done req=done within 3000 cycles");
    end
    start = 1'b0;
  endtask

  localparam logic [255:0] KEY_A =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  NONCE_A = 96'h000000090000004a00000000;

  initial begin
    logic [511:0] din_b;
    logic [511:0] din_c;
    for (int i = 0; i < 16; i++) begin
      din_b[(15 - i) * 32 +: 32] = 32'h1111_0000 * 32'(i + 1) + 32'(i);
      din_c[(15 - i) * 32 +: 32] = 32'hDEAD_0000 | 32'(i * 7);
    end

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_data_out", data_out, '0);
    check("reset_cs", bus.cs, 1'b0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Full init, ready after 10 polls: done 61 cycles after start.
    run_seq(1'b0, KEY_A, NONCE_A, 5'd20, '0, 10, 2'b00, 1'b0);
    // Next block while start is held high all the way: done at 48, one sequence only.
    run_seq(1'b1, KEY_A, NONCE_A, 5'd20, din_b, 10, 2'b00, 1'b1);
    // Status 01 for five polls, ready on the sixth.
    run_seq(1'b0, ~KEY_A, 96'h0123456789abcdef0f1e2d3c, 5'd8, din_c, 6, 2'b01, 1'b0);
    // Status stuck at 0: 1024 polls, err set, data_out untouched.
    run_seq(1'b0, KEY_A, NONCE_A, 5'd12, din_b, 0, 2'b00, 1'b0);
    @(negedge clk);
    check("err_held_after_done", err, 1'b1);

    // Reset in the middle of the nonce writes.
    ready_after = 10;
    pend = 2'b00;
    push_bus(1'b1, 8'h0b, 32'd20);
    push_bus(1'b1, 8'h0a, 32'h1);
    for (int i = 0; i < 8; i++) push_bus(1'b1, 8'(16 + i), KEY_A[(7 - i) * 32 +: 32]);
    push_bus(1'b1, 8'h20, NONCE_A[95:64]);
    push_bus(1'b1, 8'h21, NONCE_A[63:32]);
    @(negedge clk);
    mode_next = 1'b0; key = KEY_A; nonce = NONCE_A; rounds = 5'd20; data_in = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 1'b0);
    check("midreset_cs", bus.cs, 1'b0);
    check("midreset_err", err, 1'b0);
    check("midreset_data_out", data_out, '0);
    @(negedge clk);
    reset_n = 1'b1;
    last_out = '0;
    check("midreset_pending_xfers", exp_bus.size(), 0);
    run_seq(1'b0, KEY_A, NONCE_A, 5'd20, din_c, 3, 2'b00, 1'b0);

    repeat (5) @(negedge clk);
    check("final_bus_queue_empty", exp_bus.size(), 0);
    check("final_done_queue_empty", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
